// File: rtl/bus_arbiter_mux.sv
// Registered bus source selector: direct code select (legacy) or round-robin
// arbitration with bounded tenure. All outputs are registered one edge late.
module bus_arbiter_mux #(
  parameter int DATA_W   = 16,
  parameter int NUM_SRC  = 8,
  parameter int SEL_W    = 3,
  parameter int MAX_HOLD = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel_code,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC-1:0]        src_req,
  input  logic [NUM_SRC-1:0]        src_last,
  output logic [NUM_SRC-1:0]        grant,
  output logic [DATA_W-1:0]         bus_data,
  output logic                      bus_valid,
  output logic [SEL_W-1:0]          bus_owner,
  output logic                      bus_busy
);

  localparam int SLOTS = 1 << SEL_W;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_OWN  = 1'b1
  } state_t;

  state_t              r_state;
  logic [SEL_W-1:0]    r_ptr;
  logic [7:0]          r_hold;
  logic [NUM_SRC-1:0]  r_grant;
  logic [DATA_W-1:0]   r_data;
  logic                r_valid;
  logic [SEL_W-1:0]    r_owner;
  logic                r_busy;

  state_t              w_state_next;
  logic [SEL_W-1:0]    w_ptr_next;
  logic [7:0]          w_hold_next;
  logic [NUM_SRC-1:0]  w_grant_next;
  logic [DATA_W-1:0]   w_data_next;
  logic                w_valid_next;
  logic [SEL_W-1:0]    w_owner_next;
  logic                w_busy_next;

  // Every slot index reachable by a SEL_W code has an entry; slot 0 and
  // out-of-range slots read as zero and never request.
  logic [DATA_W-1:0]   w_slot [SLOTS];
  logic [SLOTS-1:0]    w_req_ext;
  logic [SLOTS-1:0]    w_last_ext;
  logic [SLOTS-1:0]    w_own_oh;
  logic [SLOTS-1:0]    w_win_oh;
  logic [SLOTS-1:0]    w_pick_req;
  logic [SEL_W-1:0]    w_pick_ptr;
  logic [SEL_W-1:0]    w_ptr_after;
  logic [SEL_W-1:0]    w_sel_direct;
  logic [SEL_W-1:0]    w_win;
  logic [SEL_W-1:0]    w_idx;
  logic                w_any;
  logic                w_release;
  logic                w_unused;

  generate
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
      if (gi > 0 && gi < NUM_SRC) begin : g_live
        assign w_slot[gi]     = src_data[gi*DATA_W +: DATA_W];
        assign w_req_ext[gi]  = src_req[gi];
        assign w_last_ext[gi] = src_last[gi];
      end else begin : g_dead
        assign w_slot[gi]     = '0;
        assign w_req_ext[gi]  = 1'b0;
        assign w_last_ext[gi] = 1'b0;
      end
      assign w_own_oh[gi] = (r_owner == SEL_W'(gi));
      assign w_win_oh[gi] = (w_win == SEL_W'(gi));
    end
  endgenerate

  assign w_unused = ^{src_req[0], src_last[0], src_data[DATA_W-1:0]};

  assign w_sel_direct = ({1'b0, sel_code} < (SEL_W+1)'(NUM_SRC)) ? sel_code : '0;
  assign w_ptr_after  = (r_owner >= SEL_W'(NUM_SRC-1)) ? SEL_W'(1) : r_owner + SEL_W'(1);
  assign w_release    = w_last_ext[r_owner] | ~w_req_ext[r_owner]
                      | (r_hold == 8'(MAX_HOLD));

  // On release the outgoing owner is masked, so it only wins again via IDLE.
  assign w_pick_ptr = (r_state == S_OWN) ? w_ptr_after : r_ptr;
  assign w_pick_req = (r_state == S_OWN) ? (w_req_ext & ~w_own_oh) : w_req_ext;

  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    w_idx = '0;
    for (int off = 0; off < NUM_SRC - 1; off++) begin
      w_idx = SEL_W'(((int'(w_pick_ptr) - 1 + off) % (NUM_SRC - 1)) + 1);
      if (!w_any && w_pick_req[w_idx]) begin
        w_win = w_idx;
        w_any = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    w_hold_next  = r_hold;
    w_grant_next = r_grant;
    w_data_next  = r_data;
    w_valid_next = r_valid;
    w_owner_next = r_owner;
    w_busy_next  = r_busy;

    if (!mode) begin
      w_state_next = S_IDLE;
      w_hold_next  = '0;
      w_grant_next = '0;
      w_busy_next  = 1'b0;
      w_owner_next = w_sel_direct;
      w_data_next  = w_slot[w_sel_direct];
      w_valid_next = (w_sel_direct != '0);
    end else begin
      if (r_state == S_OWN && !w_release) begin
        w_data_next  = w_slot[r_owner];
        w_valid_next = 1'b1;
        w_hold_next  = r_hold + 8'd1;
      end else begin
        if (r_state == S_OWN) begin
          w_ptr_next = w_ptr_after;
        end
        if (w_any) begin
          w_state_next = S_OWN;
          w_grant_next = w_win_oh[NUM_SRC-1:0];
          w_owner_next = w_win;
          w_busy_next  = 1'b1;
          w_hold_next  = 8'd1;
          w_data_next  = w_slot[w_win];
          w_valid_next = 1'b1;
        end else begin
          w_state_next = S_IDLE;
          w_grant_next = '0;
          w_owner_next = '0;
          w_busy_next  = 1'b0;
          w_hold_next  = '0;
          w_data_next  = '0;
          w_valid_next = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_ptr   <= SEL_W'(1);
      r_hold  <= '0;
      r_grant <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_owner <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
      r_hold  <= w_hold_next;
      r_grant <= w_grant_next;
      r_data  <= w_data_next;
      r_valid <= w_valid_next;
      r_owner <= w_owner_next;
      r_busy  <= w_busy_next;
    end
  end

  assign grant     = r_grant;
  assign bus_data  = r_data;
  assign bus_valid = r_valid;
  assign bus_owner = r_owner;
  assign bus_busy  = r_busy;

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Directed bench for bus_arbiter_mux: default instance plus a NUM_SRC=6
// instance for out-of-range direct codes.
module tb_bus_arbiter_mux;

  logic         clk;
  logic         reset_n;
  logic         mode;
  logic [2:0]   sel_code;
  logic [127:0] src_data;
  logic [7:0]   src_req;
  logic [7:0]   src_last;
  logic [7:0]   grant;
  logic [15:0]  bus_data;
  logic         bus_valid;
  logic [2:0]   bus_owner;
  logic         bus_busy;

  logic         b_mode;
  logic [2:0]   b_sel_code;
  logic [95:0]  b_src_data;
  logic [5:0]   b_src_req;
  logic [5:0]   b_src_last;
  logic [5:0]   b_grant;
  logic [15:0]  b_bus_data;
  logic         b_bus_valid;
  logic [2:0]   b_bus_owner;
  logic         b_bus_busy;

  int errors = 0;
  int checks = 0;

  logic [15:0] slot_val [8];

  bus_arbiter_mux #(.DATA_W(16), .NUM_SRC(8), .SEL_W(3), .MAX_HOLD(4)) u_dut (
    .clk(clk), .reset_n(reset_n), .mode(mode), .sel_code(sel_code),
    .src_data(src_data), .src_req(src_req), .src_last(src_last),
    .grant(grant), .bus_data(bus_data), .bus_valid(bus_valid),
    .bus_owner(bus_owner), .bus_busy(bus_busy)
  );

  bus_arbiter_mux #(.DATA_W(16), .NUM_SRC(6), .SEL_W(3), .MAX_HOLD(4)) u_dut6 (
    .clk(clk), .reset_n(reset_n), .mode(b_mode), .sel_code(b_sel_code),
    .src_data(b_src_data), .src_req(b_src_req), .src_last(b_src_last),
    .grant(b_grant), .bus_data(b_bus_data), .bus_valid(b_bus_valid),
    .bus_owner(b_bus_owner), .bus_busy(b_bus_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout reached before end of test");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("  ok %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_own(input string tag, input int k);
    logic [7:0] oh;
    oh = 8'd1 << k;
    chk({tag, "_owner"}, bus_owner, k);
    chk({tag, "_grant"}, grant, oh);
    chk({tag, "_data"},  bus_data, slot_val[k]);
    chk({tag, "_valid"}, bus_valid, 1);
    chk({tag, "_busy"},  bus_busy, 1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_owner"}, bus_owner, 0);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_data"},  bus_data, 0);
    chk({tag, "_valid"}, bus_valid, 0);
    chk({tag, "_busy"},  bus_busy, 0);
  endtask

  initial begin
    int rr_seq [3];
    rr_seq = '{1, 2, 5};
    slot_val = '{16'hDEAD, 16'h1111, 16'h0ABC, 16'h3333,
                 16'h4444, 16'h5555, 16'h6666, 16'hBEEF};
    for (int k = 0; k < 8; k++) src_data[k*16 +: 16] = slot_val[k];
    for (int k = 0; k < 6; k++) b_src_data[k*16 +: 16] = 16'hB000 + 16'(k);

    reset_n = 1'b0; mode = 1'b0; sel_code = 3'd3; src_req = '0; src_last = '0;
    b_mode = 1'b0; b_sel_code = 3'd0; b_src_req = '0; b_src_last = '0;

    // reset held two edges
    tick(); tick();
    chk_idle("rst");
    reset_n = 1'b1;
    tick();
    chk("rel_data", bus_data, 16'h3333);
    chk("rel_owner", bus_owner, 3);
    chk("rel_valid", bus_valid, 1);

    // direct legacy map
    sel_code = 3'd2; tick();
    chk("dir2_data", bus_data, 16'h0ABC); chk("dir2_valid", bus_valid, 1);
    sel_code = 3'd0; tick();
    chk("dir0_data", bus_data, 16'h0000); chk("dir0_valid", bus_valid, 0);
    chk("dir0_owner", bus_owner, 0);
    sel_code = 3'd7; tick();
    chk("dir7_data", bus_data, 16'hBEEF); chk("dir7_valid", bus_valid, 1);
    chk("dir7_grant", grant, 0); chk("dir7_busy", bus_busy, 0);

    // round robin 1,2,5 each for 4 cycles, no gaps
    mode = 1'b1; src_req = 8'b0010_0110;
    for (int i = 0; i < 24; i++) begin
      tick();
      chk_own($sformatf("rr%0d", i), rr_seq[(i / 4) % 3]);
    end

    // early release: owner 2 asserts last on its 2nd cycle, 5 pending
    mode = 1'b0; sel_code = 3'd0; src_req = '0; tick();
    mode = 1'b1; src_req = 8'b0000_0100; tick();
    chk_own("er_c1", 2);
    src_req = 8'b0010_0100; tick();
    chk_own("er_c2", 2);
    src_last = 8'b0000_0100; tick();
    chk_own("er_to5", 5);

    // lone requester 2: idle cycle after its src_last, then regranted
    src_last = '0; src_req = 8'b0000_0100; tick();
    chk_own("lone_g", 2);
    src_last = 8'b0000_0100; tick();
    chk_idle("lone_gap");
    src_last = '0; tick();
    chk_own("lone_re", 2);

    // slot 0 request is ignored
    src_req = 8'b0000_0001; tick();
    chk_idle("s0_a");
    tick();
    chk_idle("s0_b");

    // reset mid-tenure of slot 4, then pointer back at 1
    src_req = 8'b0001_0000; tick();
    chk_own("mr_own4", 4);
    reset_n = 1'b0; tick();
    chk_idle("mr_rst");
    reset_n = 1'b1; src_req = 8'b0001_0010; tick();
    chk_own("mr_ptr1", 1);

    // mode 1->0 mid-tenure
    mode = 1'b0; sel_code = 3'd3; tick();
    chk("ms_grant", grant, 0); chk("ms_owner", bus_owner, 3);
    chk("ms_data", bus_data, 16'h3333); chk("ms_busy", bus_busy, 0);
    chk("ms_valid", bus_valid, 1);

    // NUM_SRC=6 instance: codes 6 and 7 are out of range
    b_sel_code = 3'd5; tick();
    chk("n6_s5_data", b_bus_data, 16'hB005); chk("n6_s5_valid", b_bus_valid, 1);
    chk("n6_s5_owner", b_bus_owner, 5);
    b_sel_code = 3'd7; tick();
    chk("n6_s7_data", b_bus_data, 0); chk("n6_s7_valid", b_bus_valid, 0);
    chk("n6_s7_owner", b_bus_owner, 0);
    b_sel_code = 3'd6; tick();
    chk("n6_s6_data", b_bus_data, 0); chk("n6_s6_valid", b_bus_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
